// File: rtl/vga_palette_dac_if.sv
// Signal bundle for the palette/DAC block: pixel stream in, CPU register access, RGB/sync out.
// The master side drives the pixel stream and CPU strobes; the slave side is the DAC block.
interface vga_palette_dac_if;
  logic       ClockEnable25Mhz;
  logic [3:0] attr_i;
  logic       video_on_i;
  logic       horiz_sync_i;
  logic       vert_sync_i;
  logic       pal_we;
  logic [3:0] pal_addr;
  logic [5:0] pal_wdat;
  logic       dac_widx_we;
  logic       dac_ridx_we;
  logic [7:0] dac_index;
  logic       dac_data_we;
  logic       dac_data_re;
  logic [5:0] dac_wdat;
  logic [5:0] dac_rdat;
  logic [5:0] vga_red_o;
  logic [5:0] vga_green_o;
  logic [5:0] vga_blue_o;
  logic       vga_hsync_o;
  logic       vga_vsync_o;

  modport master (
    output ClockEnable25Mhz, attr_i, video_on_i, horiz_sync_i, vert_sync_i,
    output pal_we, pal_addr, pal_wdat,
    output dac_widx_we, dac_ridx_we, dac_index, dac_data_we, dac_data_re, dac_wdat,
    input  dac_rdat, vga_red_o, vga_green_o, vga_blue_o, vga_hsync_o, vga_vsync_o
  );

  modport slave (
    input  ClockEnable25Mhz, attr_i, video_on_i, horiz_sync_i, vert_sync_i,
    input  pal_we, pal_addr, pal_wdat,
    input  dac_widx_we, dac_ridx_we, dac_index, dac_data_we, dac_data_re, dac_wdat,
    output dac_rdat, vga_red_o, vga_green_o, vga_blue_o, vga_hsync_o, vga_vsync_o
  );
endinterface

// File: rtl/vga_palette_dac.sv
// VGA attribute palette + 256-entry RGB DAC with a 3-stage pixel pipeline and
// VGA-style sequential R/G/B CPU write and read access.
module vga_palette_dac (
  input  logic       clk,
  input  logic       rst,
  input  logic       ClockEnable25Mhz,
  input  logic [3:0] attr_i,
  input  logic       video_on_i,
  input  logic       horiz_sync_i,
  input  logic       vert_sync_i,
  input  logic       pal_we,
  input  logic [3:0] pal_addr,
  input  logic [5:0] pal_wdat,
  input  logic       dac_widx_we,
  input  logic       dac_ridx_we,
  input  logic [7:0] dac_index,
  input  logic       dac_data_we,
  input  logic       dac_data_re,
  input  logic [5:0] dac_wdat,
  output logic [5:0] dac_rdat,
  output logic [5:0] vga_red_o,
  output logic [5:0] vga_green_o,
  output logic [5:0] vga_blue_o,
  output logic       vga_hsync_o,
  output logic       vga_vsync_o
);

  typedef enum logic [1:0] {WR_R, WR_G, WR_B} wr_state_e;
  typedef enum logic [1:0] {RD_R, RD_G, RD_B} rd_state_e;

  localparam logic [5:0] PAL_DEFAULT [16] = '{
    6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h14, 6'h07,
    6'h38, 6'h39, 6'h3A, 6'h3B, 6'h3C, 6'h3D, 6'h3E, 6'h3F
  };

  logic [5:0]  pal_regs_q [16];
  logic [17:0] dac_ram [256];

  // ---------------- palette registers ----------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) pal_regs_q[i] <= PAL_DEFAULT[i];
    end else if (pal_we) begin
      pal_regs_q[pal_addr] <= pal_wdat;
    end
  end

  // ---------------- CPU write side ----------------
  wr_state_e  wr_state_q;
  logic [7:0] widx_q;
  logic [5:0] wr_r_q, wr_g_q;
  logic       wr_commit;

  // Index load beats a data strobe in the same cycle.
  assign wr_commit = !rst && !dac_widx_we && dac_data_we && (wr_state_q == WR_B);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WR_R;
      widx_q     <= '0;
      wr_r_q     <= '0;
      wr_g_q     <= '0;
    end else if (dac_widx_we) begin
      widx_q     <= dac_index;
      wr_state_q <= WR_R;
    end else if (dac_data_we) begin
      case (wr_state_q)
        WR_R: begin
          wr_r_q     <= dac_wdat;
          wr_state_q <= WR_G;
        end
        WR_G: begin
          wr_g_q     <= dac_wdat;
          wr_state_q <= WR_B;
        end
        default: begin
          widx_q     <= widx_q + 8'd1;
          wr_state_q <= WR_R;
        end
      endcase
    end
  end

  // NOTE: the colour RAM is deliberately left out of reset so it maps onto plain RAM and keeps its contents.
  always_ff @(posedge clk) begin
    if (wr_commit) dac_ram[widx_q] <= {wr_r_q, wr_g_q, dac_wdat};
  end

  // ---------------- CPU read side ----------------
  rd_state_e   rd_state_q;
  logic [7:0]  ridx_q;
  logic [7:0]  ridx_next;
  logic [17:0] rd_latch_q;
  logic        init_fetch_q;

  assign ridx_next = ridx_q + 8'd1;

  // After reset the latch is refilled from entry 0 so the read port shows real data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q   <= RD_R;
      ridx_q       <= '0;
      rd_latch_q   <= '0;
      init_fetch_q <= 1'b1;
    end else begin
      init_fetch_q <= 1'b0;
      if (dac_ridx_we) begin
        ridx_q     <= dac_index;
        rd_state_q <= RD_R;
        rd_latch_q <= dac_ram[dac_index];
      end else if (dac_data_re) begin
        case (rd_state_q)
          RD_R:    rd_state_q <= RD_G;
          RD_G:    rd_state_q <= RD_B;
          default: begin
            ridx_q     <= ridx_next;
            rd_latch_q <= dac_ram[ridx_next];
            rd_state_q <= RD_R;
          end
        endcase
      end else if (init_fetch_q) begin
        rd_latch_q <= dac_ram[ridx_q];
      end
    end
  end

  // NOTE: assign a default before the case so the combinational output never infers a latch.
  always_comb begin
    dac_rdat = rd_latch_q[17:12];
    case (rd_state_q)
      RD_G:    dac_rdat = rd_latch_q[11:6];
      RD_B:    dac_rdat = rd_latch_q[5:0];
      default: dac_rdat = rd_latch_q[17:12];
    endcase
  end

  // ---------------- pixel pipeline ----------------
  logic [5:0]  pal_q;
  logic [17:0] dac_q;
  logic [17:0] rgb_q;
  logic [17:0] rgb_d;
  logic [2:0]  vid_q, hs_q, vs_q;

  assign rgb_d = vid_q[1] ? dac_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pal_q <= '0;
      dac_q <= '0;
      rgb_q <= '0;
      vid_q <= '0;
      hs_q  <= '0;
      vs_q  <= '0;
    end else if (ClockEnable25Mhz) begin
      pal_q <= pal_regs_q[attr_i];
      dac_q <= dac_ram[{2'b00, pal_q}];
      rgb_q <= rgb_d;
      vid_q <= {vid_q[1:0], video_on_i};
      hs_q  <= {hs_q[1:0], horiz_sync_i};
      vs_q  <= {vs_q[1:0], vert_sync_i};
    end
  end

  assign vga_red_o   = rgb_q[17:12];
  assign vga_green_o = rgb_q[11:6];
  assign vga_blue_o  = rgb_q[5:0];
  assign vga_hsync_o = hs_q[2];
  assign vga_vsync_o = vs_q[2];

endmodule

// File: tb/tb_vga_palette_dac.sv
// Directed self-checking bench for vga_palette_dac: CPU DAC access, index wrap,
// reset behaviour, pixel pipeline latency, blanking and palette update.
module tb_vga_palette_dac;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  vga_palette_dac_if vif ();

  vga_palette_dac dut (
    .clk              (clk),
    .rst              (rst),
    .ClockEnable25Mhz (vif.ClockEnable25Mhz),
    .attr_i           (vif.attr_i),
    .video_on_i       (vif.video_on_i),
    .horiz_sync_i     (vif.horiz_sync_i),
    .vert_sync_i      (vif.vert_sync_i),
    .pal_we           (vif.pal_we),
    .pal_addr         (vif.pal_addr),
    .pal_wdat         (vif.pal_wdat),
    .dac_widx_we      (vif.dac_widx_we),
    .dac_ridx_we      (vif.dac_ridx_we),
    .dac_index        (vif.dac_index),
    .dac_data_we      (vif.dac_data_we),
    .dac_data_re      (vif.dac_data_re),
    .dac_wdat         (vif.dac_wdat),
    .dac_rdat         (vif.dac_rdat),
    .vga_red_o        (vif.vga_red_o),
    .vga_green_o      (vif.vga_green_o),
    .vga_blue_o       (vif.vga_blue_o),
    .vga_hsync_o      (vif.vga_hsync_o),
    .vga_vsync_o      (vif.vga_vsync_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [17:0] observed, input logic [17:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_idx(input logic [7:0] idx);
    vif.dac_widx_we = 1'b1;
    vif.dac_index   = idx;
    tick();
    vif.dac_widx_we = 1'b0;
  endtask

  task automatic wr_data(input logic [5:0] d);
    vif.dac_data_we = 1'b1;
    vif.dac_wdat    = d;
    tick();
    vif.dac_data_we = 1'b0;
  endtask

  task automatic rd_idx(input logic [7:0] idx);
    vif.dac_ridx_we = 1'b1;
    vif.dac_index   = idx;
    tick();
    vif.dac_ridx_we = 1'b0;
    tick();
  endtask

  task automatic rd_data(input string tag, input logic [5:0] expected);
    check(tag, {12'h000, vif.dac_rdat}, {12'h000, expected});
    vif.dac_data_re = 1'b1;
    tick();
    vif.dac_data_re = 1'b0;
  endtask

  // One enabled edge followed by one non-enabled edge: pixel enable every other clk.
  task automatic en_tick();
    vif.ClockEnable25Mhz = 1'b1;
    tick();
    vif.ClockEnable25Mhz = 1'b0;
    tick();
  endtask

  function automatic logic [17:0] rgb();
    return {vif.vga_red_o, vif.vga_green_o, vif.vga_blue_o};
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    vif.ClockEnable25Mhz = 1'b0;
    vif.attr_i       = 4'h0;
    vif.video_on_i   = 1'b0;
    vif.horiz_sync_i = 1'b0;
    vif.vert_sync_i  = 1'b0;
    vif.pal_we       = 1'b0;
    vif.pal_addr     = 4'h0;
    vif.pal_wdat     = 6'h00;
    vif.dac_widx_we  = 1'b0;
    vif.dac_ridx_we  = 1'b0;
    vif.dac_index    = 8'h00;
    vif.dac_data_we  = 1'b0;
    vif.dac_data_re  = 1'b0;
    vif.dac_wdat     = 6'h00;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state of the video outputs.
    check("reset_rgb",   rgb(), 18'h0);
    check("reset_hsync", {17'h0, vif.vga_hsync_o}, 18'h0);
    check("reset_vsync", {17'h0, vif.vga_vsync_o}, 18'h0);

    // Index load and data strobe together: data ignored, sequence restarts at R.
    vif.dac_widx_we = 1'b1;
    vif.dac_index   = 8'h20;
    vif.dac_data_we = 1'b1;
    vif.dac_wdat    = 6'h15;
    tick();
    vif.dac_widx_we = 1'b0;
    vif.dac_data_we = 1'b0;
    wr_data(6'h01);
    wr_data(6'h02);
    wr_data(6'h03);
    rd_idx(8'h20);
    rd_data("coll_r", 6'h01);
    rd_data("coll_g", 6'h02);
    rd_data("coll_b", 6'h03);

    // Write sequence at 5, continuing into 6; read back across the entry boundary.
    wr_idx(8'h05);
    wr_data(6'h3F);
    wr_data(6'h00);
    wr_data(6'h2A);
    wr_data(6'h11);
    wr_data(6'h22);
    wr_data(6'h33);
    rd_idx(8'h05);
    rd_data("seq_r", 6'h3F);
    rd_data("seq_g", 6'h00);
    rd_data("seq_b", 6'h2A);
    rd_data("seq_next_idx6_r", 6'h11);

    // Write index wrap 0xFF -> 0x00 -> 0x01.
    wr_idx(8'hFF);
    wr_data(6'h01);
    wr_data(6'h02);
    wr_data(6'h03);
    wr_data(6'h04);
    wr_data(6'h05);
    wr_data(6'h06);
    wr_data(6'h07);
    wr_data(6'h08);
    wr_data(6'h09);
    rd_idx(8'hFF);
    rd_data("wrap_ff_r", 6'h01);
    rd_data("wrap_ff_g", 6'h02);
    rd_data("wrap_ff_b", 6'h03);
    rd_data("wrap_00_r", 6'h04);
    rd_data("wrap_00_g", 6'h05);
    rd_data("wrap_00_b", 6'h06);
    rd_data("wrap_01_r", 6'h07);

    // Two partial writes, then reset: partial components must be discarded.
    wr_data(6'h2A);
    wr_data(6'h2B);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("post_reset_rdat_dac0_r", {12'h000, vif.dac_rdat}, {12'h000, 6'h04});
    wr_data(6'h0A);
    wr_data(6'h0B);
    wr_data(6'h0C);
    rd_idx(8'h00);
    rd_data("rstmid_r", 6'h0A);
    rd_data("rstmid_g", 6'h0B);
    rd_data("rstmid_b", 6'h0C);

    // Pixel path: palette default entry 6 -> DAC 0x14.
    wr_idx(8'h14);
    wr_data(6'h3F);
    wr_data(6'h3F);
    wr_data(6'h00);
    vif.attr_i       = 4'h6;
    vif.video_on_i   = 1'b1;
    vif.horiz_sync_i = 1'b1;
    vif.vert_sync_i  = 1'b0;
    en_tick();
    check("pix_e1_rgb",   rgb(), 18'h0);
    check("pix_e1_hsync", {17'h0, vif.vga_hsync_o}, 18'h0);
    en_tick();
    check("pix_e2_rgb",   rgb(), 18'h0);
    check("pix_e2_hsync", {17'h0, vif.vga_hsync_o}, 18'h0);
    en_tick();
    check("pix_e3_rgb",   rgb(), {6'h3F, 6'h3F, 6'h00});
    check("pix_e3_hsync", {17'h0, vif.vga_hsync_o}, 18'h1);

    // Blanking: RGB forced to 0 three enabled cycles later, syncs still delayed.
    vif.video_on_i   = 1'b0;
    vif.horiz_sync_i = 1'b0;
    vif.vert_sync_i  = 1'b1;
    en_tick();
    en_tick();
    check("blank_e2_rgb",   rgb(), {6'h3F, 6'h3F, 6'h00});
    check("blank_e2_vsync", {17'h0, vif.vga_vsync_o}, 18'h0);
    en_tick();
    check("blank_e3_rgb",   rgb(), 18'h0);
    check("blank_e3_vsync", {17'h0, vif.vga_vsync_o}, 18'h1);
    check("blank_e3_hsync", {17'h0, vif.vga_hsync_o}, 18'h0);

    // Palette write: entry 6 now points at DAC 0x20 = {01,02,03}.
    vif.pal_we   = 1'b1;
    vif.pal_addr = 4'h6;
    vif.pal_wdat = 6'h20;
    tick();
    vif.pal_we     = 1'b0;
    vif.video_on_i = 1'b1;
    en_tick();
    en_tick();
    en_tick();
    check("palwr_rgb", rgb(), {6'h01, 6'h02, 6'h03});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vga_palette_dac.md
VGA_PALETTE_DAC -- requirements
Module: vga_palette_dac

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ClockEnable25Mhz  in  1  pixel-clock enable; the pixel pipeline advances only when high
- attr_i  in  4  pixel attribute from the text/graphics stage
- video_on_i  in  1  active-video flag, aligned with attr_i
- horiz_sync_i  in  1  horizontal sync, aligned with attr_i
- vert_sync_i  in  1  vertical sync, aligned with attr_i
- pal_we  in  1  palette register write strobe
- pal_addr  in  4  palette register index
- pal_wdat  in  6  palette register data
- dac_widx_we  in  1  load DAC write index
- dac_ridx_we  in  1  load DAC read index
- dac_index  in  8  index value for the two index loads
- dac_data_we  in  1  DAC data write strobe (one colour component)
- dac_data_re  in  1  DAC data read strobe (one colour component)
- dac_wdat  in  6  DAC component write data
- dac_rdat  out  6  DAC component read data
- vga_red_o  out  6  red output
- vga_green_o  out  6  green output
- vga_blue_o  out  6  blue output
- vga_hsync_o  out  1  delayed horizontal sync
- vga_vsync_o  out  1  delayed vertical sync

REQ-002 Reset is rst, synchronous, active-high; the clock is clk.

REQ-003 CPU-side strobes act on every clk edge and are not gated by ClockEnable25Mhz.

Function
REQ-010 Storage:
- 16 x 6-bit palette registers.
- 256 x 18-bit DAC RAM holding {R,G,B}, dual-ported: one port for pixel read, one for CPU access.

REQ-011 Pixel pipeline, 3 stages, advancing only on enabled cycles:
- S1: pal_q <= palette[attr_i].
- S2: dac_q <= DAC[{2'b00,pal_q}].
- S3: RGB outputs <= dac_q, or 0 when the delayed video_on is low.

REQ-012 video_on, hsync and vsync SHALL be delayed by exactly 3 enabled cycles so they stay aligned with the RGB outputs.

REQ-013 Total latency from attr_i to RGB SHALL be 3 enabled cycles; outputs hold their values on non-enabled cycles.

REQ-014 Palette write: pal_we writes pal_wdat into palette[pal_addr] at the clock edge. A pixel S1 lookup in that same cycle returns the old value.

REQ-015 DAC write FSM has states WR_R, WR_G, WR_B.
- dac_widx_we: write index <= dac_index, FSM -> WR_R.
- dac_data_we in WR_R or WR_G: latch the component, advance to the next state.
- dac_data_we in WR_B: commit {r,g,b} to DAC[write index] in one cycle, increment write index (255 wraps to 0), FSM -> WR_R.

REQ-016 DAC read FSM has states RD_R, RD_G, RD_B.
- dac_ridx_we: read index <= dac_index, FSM -> RD_R, prefetch DAC[dac_index] into the read latch.
- dac_rdat SHALL present the latched component for the current state, valid 2 clk after the index load.
- dac_data_re in RD_R or RD_G: advance to the next state.
- dac_data_re in RD_B: increment read index (wrap 255 to 0), refetch, FSM -> RD_R.

REQ-017 If an index load and a data strobe of the same FSM occur in the same cycle, the load wins and the data strobe is ignored.

REQ-018 The read and write FSMs are independent. Simultaneous write and read strobes both take effect.

REQ-019 A commit to the DAC entry currently being displayed SHALL be visible at S2 on the first enabled cycle after the commit edge. A read prefetch of the same address in the commit cycle returns the old data.

REQ-020 dac_rdat is never X after reset; before any read index load it shows DAC[0] component R.

Reset
REQ-030 On rst, both FSMs and indices reset:
- Write and read FSMs -> R state; write and read indices -> 0.
- Partial component latches are discarded, including mid-sequence.

REQ-031 On rst, pipeline and outputs reset:
- Pipeline registers, delay lines, all RGB outputs and both syncs -> 0.

REQ-032 On rst, the palette loads defaults 00,01,02,03,04,05,14,07,38,39,3A,3B,3C,3D,3E,3F (hex).

REQ-033 DAC RAM contents are not affected by rst.

Verification
REQ-040 Write sequence:
- Stimulus: dac_widx_we idx=0x05, then writes 0x3F, 0x00, 0x2A.
- Then: dac_ridx_we idx=0x05, read three times.
- Response: reads return 3F, 00, 2A; read index ends at 0x06.

REQ-041 Index wrap:
- Stimulus: write index 0xFF, then 6 component writes.
- Response: entries 0xFF and 0x00 are both updated; write index ends at 0x01.

REQ-042 Pixel path:
- Stimulus: after reset, DAC[0x14] = {0x3F,0x3F,0x00}; attr_i = 6 with video_on = 1, ClockEnable25Mhz every other clk.
- Response: RGB = 3F,3F,00 on the 3rd enabled edge; hsync is delayed by the same 3 enabled edges.

REQ-043 Blanking:
- Stimulus: video_on = 0 with any attr_i.
- Response: RGB = 0 three enabled cycles later; syncs still pass through.

REQ-044 Reset mid-sequence:
- Stimulus: two component writes, then rst, then 3 writes at index 0.
- Response: DAC[0] equals the last 3 values; no stale component is committed.

REQ-045 Collision:
- Stimulus: dac_widx_we and dac_data_we in the same cycle.
- Response: the data is ignored and the FSM stays in WR_R.
